// File: rtl/uart_rx_if.sv
// Handshake and status bundle between the UART receive core and its host side.
// Master drives the line, tick, configuration and read strobe; slave is the core.
interface uart_rx_if;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  modport master (
    output baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte,
    input  rx_byte, rx_ready, parity_err, framing_err, overflow
  );

  modport slave (
    input  baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte,
    output rx_byte, rx_ready, parity_err, framing_err, overflow
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises and majority-filters rx on the 16x tick, frames
// start/data/parity/stop bits and presents the byte with a ready/read handshake.
module uart_rx_core #(
  parameter bit RX_LEGACY_MODE = 1'b0
) (
  input logic     i_clk,
  input logic     i_reset,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  logic       r_sync1, r_sync2;
  logic [2:0] r_hist;
  state_e     r_state, w_state_d;
  logic [3:0] r_tick, w_tick_d;
  logic [2:0] r_bit, w_bit_d;
  logic [7:0] r_shift, w_shift_d;
  logic       r_perr, w_perr_d;
  logic [7:0] r_rx_byte;
  logic       r_rx_ready, r_parity_err, r_framing_err, r_overflow;

  logic       w_filt;
  logic [7:0] w_data;
  logic [2:0] w_last_bit;
  logic       w_complete;
  logic       w_stop;

  assign w_filt     = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  // In 7-bit mode bit 7 of the shift register is stale, so it is masked out.
  assign w_data     = {bus.bit8 & r_shift[7], r_shift[6:0]};
  assign w_last_bit = bus.bit8 ? 3'd7 : 3'd6;

  always_comb begin
    w_state_d  = r_state;
    w_tick_d   = r_tick;
    w_bit_d    = r_bit;
    w_shift_d  = r_shift;
    w_perr_d   = r_perr;
    w_complete = 1'b0;
    w_stop     = 1'b1;
    if (bus.baud_clock) begin
      unique case (r_state)
        StIdle: begin
          if (!w_filt) begin
            w_state_d = StStart;
            w_tick_d  = 4'd0;
          end
        end
        StStart: begin
          w_tick_d = r_tick + 4'd1;
          if (r_tick == 4'd7) begin
            if (w_filt) begin
              w_state_d = StIdle;
            end else begin
              w_state_d = StData;
              w_tick_d  = 4'd0;
              w_bit_d   = 3'd0;
              w_perr_d  = 1'b0;
            end
          end
        end
        StData: begin
          w_tick_d = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_shift_d[r_bit] = w_filt;
            w_bit_d          = r_bit + 3'd1;
            // >= keeps a mid-frame switch to 7-bit mode from running past the end.
            if (r_bit >= w_last_bit) w_state_d = bus.parity_en ? StParity : StStop;
          end
        end
        StParity: begin
          w_tick_d = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_perr_d  = (((^w_data) ^ w_filt) != bus.odd_n_even);
            w_state_d = StStop;
          end
        end
        StStop: begin
          w_tick_d = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_complete = 1'b1;
            w_stop     = w_filt;
            w_state_d  = w_filt ? StIdle : StBreak;
          end
        end
        StBreak: begin
          if (w_filt) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
      r_state <= StIdle;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_perr  <= 1'b0;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      if (bus.baud_clock) r_hist <= {r_hist[1:0], r_sync2};
      r_state <= w_state_d;
      r_tick  <= w_tick_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_perr  <= w_perr_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_byte     <= 8'd0;
      r_rx_ready    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (w_complete) begin
      if (!r_rx_ready || bus.read_rx_byte) begin
        r_rx_byte     <= w_data;
        r_rx_ready    <= !(RX_LEGACY_MODE && bus.read_rx_byte);
        r_parity_err  <= r_perr & bus.parity_en;
        r_framing_err <= ~w_stop;
        if (bus.read_rx_byte) r_overflow <= 1'b0;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (bus.read_rx_byte && r_rx_ready) begin
      r_rx_ready <= 1'b0;
      r_overflow <= 1'b0;
    end
  end

  assign bus.rx_byte     = r_rx_byte;
  assign bus.rx_ready    = r_rx_ready;
  assign bus.parity_err  = r_parity_err;
  assign bus.framing_err = r_framing_err;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are bit-banged at 16 ticks per bit with
// a baud tick every 4 clk, and outputs are compared against hand-computed values.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_if u_if ();

  uart_rx_core #(.RX_LEGACY_MODE(1'b0)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    u_if.baud_clock = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      u_if.baud_clock = 1'b1;
      @(negedge clk);
      u_if.baud_clock = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] b, input logic rdy,
                           input logic pe, input logic fe, input logic ov);
    check_eq({tag, ".byte"}, u_if.rx_byte, b);
    check_eq({tag, ".ready"}, {7'd0, u_if.rx_ready}, {7'd0, rdy});
    check_eq({tag, ".perr"}, {7'd0, u_if.parity_err}, {7'd0, pe});
    check_eq({tag, ".ferr"}, {7'd0, u_if.framing_err}, {7'd0, fe});
    check_eq({tag, ".ovf"}, {7'd0, u_if.overflow}, {7'd0, ov});
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    u_if.rx = b;
    wait_ticks(16);
  endtask

  // Leaves the line at the stop level so a low stop bit can be extended by the caller.
  task automatic send_frame(input logic [7:0] data, input bit b8, input bit par,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < (b8 ? 8 : 7); i++) send_bit(data[i]);
    if (par) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    u_if.read_rx_byte = 1'b1;
    @(negedge clk);
    u_if.read_rx_byte = 1'b0;
    @(negedge clk);
  endtask

  // Times the read strobe onto the completion clk so both land on the same edge.
  task automatic read_at_complete();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dut.w_complete) seen = 1'b1;
    end
    if (seen) begin
      u_if.read_rx_byte = 1'b1;
      @(posedge clk);
      #1;
      u_if.read_rx_byte = 1'b0;
    end
    check_eq("sync_read_seen", {7'd0, seen}, 8'd1);
  endtask

  initial begin
    u_if.rx           = 1'b1;
    u_if.read_rx_byte = 1'b0;
    u_if.bit8         = 1'b1;
    u_if.parity_en    = 1'b0;
    u_if.odd_n_even   = 1'b0;
    reset             = 1'b1;
    repeat (3) @(negedge clk);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    read_pulse();
    check_out("a5_read", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // 7E1 0x41: correct even parity bit is 0
    u_if.bit8      = 1'b0;
    u_if.parity_en = 1'b1;
    wait_ticks(4);
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_ticks(2);
    check_out("p_bad", 8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
    read_pulse();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("p_good", 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    read_pulse();
    u_if.bit8      = 1'b1;
    u_if.parity_en = 1'b0;
    wait_ticks(4);

    // Low stop bit followed by a held-low line
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("brk", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    read_pulse();
    wait_ticks(40);
    check_out("brk_low", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    u_if.rx = 1'b1;
    wait_ticks(32);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("after_brk", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    read_pulse();

    // 6-tick glitch must be rejected as a false start
    u_if.rx = 1'b0;
    wait_ticks(6);
    u_if.rx = 1'b1;
    wait_ticks(48);
    check_out("glitch", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("post_glitch", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    read_pulse();

    // Overflow: second frame lands while the first is unread
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("ovf", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    read_pulse();
    check_out("ovf_read", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Read strobe coincident with completion
    send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("hold66", 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
      read_at_complete();
    join
    wait_ticks(2);
    check_out("same_clk", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_ticks(8);
    reset = 1'b1;
    #1;
    check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    u_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ticks(40);
    check_out("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    check_out("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive engine, directly downstream of the baud clock generator; consumes its 1-clk-wide 16x-oversample tick (baud_clock).
- Synchronises and majority-filters the serial line, then detects the start bit and samples each bit at mid-bit.
- Checks optional parity and the stop bit, and presents the received byte with a ready/read handshake plus error flags to the APB register layer.

Parameters:
- RX_LEGACY_MODE, 0, 1 = rx_ready clears on the clk after read_rx_byte regardless of a new byte; 0 = behaviour below.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- baud_clock  in  1  16x oversample tick from the baud generator, 1 clk wide
- rx  in  1  asynchronous serial input, idle high
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  parity bit present and checked
- odd_n_even  in  1  1 = odd parity, 0 = even parity
- read_rx_byte  in  1  1-clk pulse from host consuming rx_byte
- rx_byte  out  8  received data, LSB first on the line; bit7 = 0 in 7-bit mode
- rx_ready  out  1  byte available
- parity_err  out  1  parity error on last completed frame
- framing_err  out  1  stop bit sampled low on last completed frame
- overflow  out  1  sticky: frame completed while rx_ready still set

Behaviour:
- Reset: rx_byte = 0; rx_ready, parity_err, framing_err, overflow = 0; sync flops = 1; state IDLE; counters 0.
- Input path: 2-flop synchroniser on clk. On each baud_clock, shift the synced bit into a 3-bit history; rx_filt = majority(history). History resets to 3'b111.
- All state, counter and sample activity advances only on clk edges where baud_clock = 1. The exceptions are the host handshake and register updates, which are clk-level.
- tick_cnt is 4-bit; bit_cnt is 3-bit.
- FSM IDLE: when rx_filt = 0, go to START with tick_cnt = 0.
- FSM START: increment tick_cnt. At tick_cnt = 7, sample rx_filt. If 1, treat as a false start and return to IDLE. If 0, go to DATA with tick_cnt = 0 and bit_cnt = 0.
- FSM DATA: at tick_cnt = 15, sample rx_filt into shift[bit_cnt] and increment bit_cnt. After bit 7 (bit8 = 1) or bit 6 (bit8 = 0), go to PARITY if parity_en, else STOP. tick_cnt wraps 15 -> 0.
- FSM PARITY: at tick_cnt = 15, sample the parity bit. perr = (XOR of data bits XOR parity bit) != odd_n_even. Then go to STOP.
- FSM STOP: at tick_cnt = 15, sample the stop bit and complete the frame (see below). Go to IDLE if the stop bit = 1, else BREAK.
- FSM BREAK: stay until rx_filt = 1, then go to IDLE. No new start is detected while the line is held low.
- Frame completion, all in the same clk as the stop sample:
  - rx_ready = 0 or read_rx_byte = 1: load rx_byte (7-bit mode zero-fills bit7), set rx_ready = 1, parity_err = perr & parity_en, framing_err = ~stop.
  - rx_ready = 1 and read_rx_byte = 0: set overflow = 1. rx_byte and the error flags are left unchanged; the new frame is discarded.
- read_rx_byte with no completion in the same clk: rx_ready = 0 on the next clk; overflow = 0; parity_err and framing_err are held.
- read_rx_byte when rx_ready = 0: no effect.
- Latency: rx_ready rises 1 clk after the stop-bit sample tick. That tick is about mid-stop-bit, plus 2 clk sync plus filter delay.
- Config changes (bit8, parity_en, odd_n_even) mid-frame: sampled live; the frame result is undefined. Must not hang the FSM, which returns to IDLE within one frame time.
- Reset asserted mid-frame: immediate return to reset state; a partial frame is never reported.
- baud_clock stuck low: FSM and outputs frozen; the handshake still works.

Test Plan:
- baud_clock every 4 clk; 8N1 frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 ticks/bit -> rx_byte = 0xA5, rx_ready = 1, all errors 0; read_rx_byte -> rx_ready = 0.
- 7-bit, even parity, data 0x41 with parity bit 1 -> rx_byte = 0x41, parity_err = 1. Repeat with parity bit 0 -> parity_err = 0.
- 8N1 0x3C with stop bit 0 and line held low for 40 ticks, then high, then frame 0x55 -> first frame framing_err = 1; no spurious byte during the low period; 0x55 received with framing_err = 0.
- Low glitch of 6 ticks on idle line -> false start rejected; rx_ready stays 0 and the FSM returns to IDLE.
- Two frames 0x11, 0x22 with no read -> rx_byte = 0x11, overflow = 1. Then read_rx_byte -> overflow = 0 and rx_ready = 0.
- read_rx_byte asserted in the same clk as completion of frame 0x77 while holding 0x66 -> rx_byte = 0x77, rx_ready = 1, overflow = 0. Also: reset pulse mid-DATA -> all outputs 0 and the next clean frame is received correctly.
